// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the fetch PC, applies EX redirects, squashes wrong-path work.
// Optional: define PC_ALIGN_CHECK_EN to word-align redirect targets and flag misaligned ones.
module fetch_pc_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  pc_out,
    output logic             fetch_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             misalign
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv;
    logic              accept;
    logic              in_pend;
    logic [PC_W-1:0]   tgt;
    logic              mis_hit;

    // Upper target bits lie outside the fetch address space.
    logic unused_br_hi;
    assign unused_br_hi = &{1'b0, br_pc[31:PC_W]};

    assign adv     = !stall && imem_ready;
    assign in_pend = (state_q == PEND);
    assign accept  = !in_pend && pc_sel;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt     = {br_pc[PC_W-1:2], 2'b00};
    assign mis_hit = |br_pc[1:0];
`else
    assign tgt     = br_pc[PC_W-1:0];
    assign mis_hit = 1'b0;
`endif

    // Next-state: redirect beats stall; PEND waits only on imem_ready.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (pc_sel) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = PEND;
                    end
                end else if (adv) begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            PEND: begin
                if (imem_ready) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;

    // One-cycle pulse for each accepted misaligned redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept && mis_hit;
        end
    end

    assign misalign = mis_q;
`else
    logic unused_mis;
    assign unused_mis = &{1'b0, mis_hit};
    assign misalign   = 1'b0;
`endif

    assign pc_out       = pc_q;
    assign redirect_cnt = cnt_q;

    // Handshake and squash outputs are forced low in the reset cycle.
    assign fetch_valid      = !reset && !in_pend && adv && !pc_sel;
    assign flush_idex       = !reset && accept;
    assign flush_ifid       = !reset && (accept || in_pend);
    assign redirect_pending = !reset && in_pend;

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Consumer end of the branch-resolution interface: owns the architectural fetch PC register and acts on the redirect (pc_sel, br_pc) produced in EX.
- Sequences the PC as PC+4, taken redirect, hold on stall, or hold on instruction-memory back-pressure.
- Generates IF/ID and ID/EX squash signals for wrong-path instructions.
- Sits between the EX-stage branch resolver, the hazard unit and instruction memory.

Parameters:
- PC_W, 9, width of fetch PC; matches the branch resolver's Cur_PC width.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).
- CNT_W, 16, width of the taken-redirect performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- pc_sel  in  1  EX redirect request; 1 = branch/jump taken.
- br_pc  in  32  redirect target; bits [31:PC_W] ignored.
- imem_ready  in  1  instruction memory accepts a fetch at pc_out this cycle.
- pc_out  out  PC_W  current fetch address.
- fetch_valid  out  1  instruction fetched at pc_out this cycle is valid for IF/ID.
- flush_ifid  out  1  squash IF/ID register.
- flush_idex  out  1  squash ID/EX register.
- redirect_pending  out  1  accepted redirect not yet applied to pc_out.
- redirect_cnt  out  CNT_W  count of accepted redirects; saturates at all-ones.
- misalign  out  1  redirect target not word-aligned; optional feature only.

Behaviour:
- Reset, synchronous, overrides everything:
  - pc_out = RESET_PC; state = RUN; pending target = 0; redirect_cnt = 0; misalign = 0.
  - fetch_valid, flush_ifid, flush_idex and redirect_pending are all 0 during the reset cycle.
- Reset asserted mid-PEND discards the pending target. fetch_valid may rise in the first cycle after reset deasserts.
- adv = !stall && imem_ready.
- FSM, 2 states:
  - RUN: redirect_pending = 0.
    - pc_sel = 1 → accept redirect, regardless of stall: flush_ifid = flush_idex = 1 combinationally the same cycle; redirect_cnt += 1.
      - If imem_ready = 1: pc_out ← br_pc[PC_W-1:0] next edge; stay RUN.
      - Else: latch br_pc[PC_W-1:0] into pending register; go to PEND.
    - pc_sel = 0 and adv = 1 → pc_out ← pc_out + 4, modulo 2^PC_W (e.g. 0x1FC → 0x000).
    - pc_sel = 0 and adv = 0 → pc_out holds.
  - PEND: redirect_pending = 1; flush_ifid = 1 every cycle; flush_idex = 0; fetch_valid = 0; pc_sel ignored.
    - When imem_ready = 1: pc_out ← pending target; go to RUN. Stall is ignored here because the pipeline front is empty.
- fetch_valid = imem_ready && !stall && !pc_sel && state == RUN (combinational).
- Stall and pc_sel in the same cycle: redirect wins. The stalled instruction is on the wrong path, so it is squashed.
- pc_sel held high for several cycles counts once per cycle. The upstream resolver guarantees a single-cycle pulse; the bench checks the count.
- Latency: redirect-to-new-pc_out is 1 cycle when imem_ready = 1; otherwise 1 cycle after imem_ready rises.
- redirect_cnt stops at 2^CNT_W − 1; no wrap.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - On an accepted redirect with br_pc[1:0] != 0, misalign is a 1-cycle registered pulse on the next edge.
  - The target applied, or latched as pending, is forced to {br_pc[PC_W-1:2], 2'b00}.
  - redirect_cnt still increments.
- Undefined: misalign is tied to 0; br_pc[PC_W-1:0] is used unmodified.

Test Plan:
- Reset then free run: reset 2 cycles, then stall = 0, imem_ready = 1 → pc_out 0x000, 0x004, 0x008, …; at 0x1FC the next value is 0x000; fetch_valid = 1 throughout.
- Taken redirect: pc_out = 0x010, pc_sel = 1, br_pc = 0x0000_0040 → same cycle flush_ifid = flush_idex = 1 and fetch_valid = 0; next edge pc_out = 0x040; redirect_cnt = 1.
- Redirect under back-pressure: pc_sel = 1, br_pc = 0x080, imem_ready = 0 for 3 cycles → redirect_pending = 1 and flush_ifid = 1 for 3 cycles, pc_out unchanged; a pc_sel pulse (br_pc = 0x0C0) injected during PEND is ignored; the edge after imem_ready = 1 gives pc_out = 0x080 and redirect_pending = 0.
- Stall vs redirect collision: stall = 1 and pc_sel = 1 with br_pc = 0x100 → redirect taken, pc_out = 0x100 next edge; stall alone for 4 cycles holds pc_out and fetch_valid = 0.
- Reset mid-PEND: enter PEND with target 0x060, assert reset → pc_out = RESET_PC, redirect_pending = 0, redirect_cnt = 0; 0x060 is never applied.
- Alignment (PC_ALIGN_CHECK_EN defined): br_pc = 0x0000_0046 → misalign pulses 1 cycle, pc_out = 0x044. With the macro undefined: pc_out = 0x046, misalign = 0.
